// File: rtl/srec_emitter_if.sv
// Memory-read and character-stream bus of the S-record emitter.
// master: emitter side (read_* requests, char_* out); slave: memory/UART side.
interface srec_emitter_if;
  logic        read_request;
  logic [31:0] read_address;
  logic [7:0]  read_data;
  logic        read_valid;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;

  modport master (
    output read_request, read_address, char_data, char_valid,
    input  read_data, read_valid, char_ready
  );

  modport slave (
    input  read_request, read_address, char_data, char_valid,
    output read_data, read_valid, char_ready
  );
endinterface

// File: rtl/srec_emitter.sv
// Dumps a memory range as Motorola S3 records plus a closing S7 record.
// Ports: clock, reset_n, start/start_address/byte_count, busy, done, bus.
module srec_emitter (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [31:0]    start_address,
  input  logic [15:0]    byte_count,
  output logic           busy,
  output logic           done,
  srec_emitter_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, TYPE, COUNT, ADDR, FETCH, DATA, CSUM, CR, LF
  } state_t;

  state_t      state, state_d;
  logic [2:0]  nib, nib_d;
  logic        s7;
  logic [15:0] rem;
  logic [4:0]  n;
  logic [4:0]  rec_left;
  logic [31:0] cur, rec_addr, base;
  logic [7:0]  dbyte, sum, cnt;
  logic        sent, done_q;
  logic        acc, go, setup, fin, is_hex;
  logic [3:0]  hv;

  // Record setup: from IDLE it uses the start inputs, otherwise
  // the running remainder and the next read address.
  logic [15:0] rem_src;
  logic [31:0] addr_src, base_src, a_new;
  logic        s7_new;
  logic [4:0]  n_new;
  logic [7:0]  cnt_new, sum_new;

  assign rem_src  = (state == IDLE) ? byte_count : rem;
  assign addr_src = (state == IDLE) ? start_address : cur;
  assign base_src = (state == IDLE) ? start_address : base;
  assign s7_new   = (rem_src == 16'd0);
  assign n_new    = s7_new ? 5'd0 :
                    (rem_src > 16'd16) ? 5'd16 : rem_src[4:0];
  assign a_new    = s7_new ? base_src : addr_src;
  assign cnt_new  = {3'b000, n_new} + 8'd5;
  assign sum_new  = cnt_new + a_new[31:24] + a_new[23:16]
                  + a_new[15:8] + a_new[7:0];

  assign cnt  = {3'b000, n} + 8'd5;
  assign acc  = bus.char_valid & bus.char_ready;
  assign go   = start & (state == IDLE) & ~done_q;
  assign busy = (state != IDLE) | done_q;
  assign done = done_q;
  assign bus.read_address = cur;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      nib   <= 3'd0;
    end else begin
      state <= state_d;
      nib   <= nib_d;
    end
  end

  always_comb begin
    state_d          = state;
    nib_d            = nib;
    bus.char_valid   = 1'b0;
    bus.char_data    = 8'h00;
    bus.read_request = 1'b0;
    setup            = 1'b0;
    fin              = 1'b0;
    is_hex           = 1'b0;
    hv               = 4'h0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_d = TYPE;
          nib_d   = 3'd0;
          setup   = 1'b1;
        end
      end
      TYPE: begin
        bus.char_valid = 1'b1;
        bus.char_data  = !nib[0] ? 8'h53 : (s7 ? 8'h37 : 8'h33);
        if (acc) begin
          nib_d = nib + 3'd1;
          if (nib[0]) begin
            state_d = COUNT;
            nib_d   = 3'd0;
          end
        end
      end
      COUNT: begin
        bus.char_valid = 1'b1;
        is_hex         = 1'b1;
        hv             = nib[0] ? cnt[3:0] : cnt[7:4];
        if (acc) begin
          nib_d = nib + 3'd1;
          if (nib[0]) begin
            state_d = ADDR;
            nib_d   = 3'd0;
          end
        end
      end
      ADDR: begin
        bus.char_valid = 1'b1;
        is_hex         = 1'b1;
        hv             = 4'(rec_addr >> {~nib, 2'b00});
        if (acc) begin
          nib_d = nib + 3'd1;
          if (nib == 3'd7) begin
            state_d = s7 ? CSUM : FETCH;
            nib_d   = 3'd0;
          end
        end
      end
      FETCH: begin
        bus.read_request = ~sent;
        if (sent && bus.read_valid) begin
          state_d = DATA;
          nib_d   = 3'd0;
        end
      end
      DATA: begin
        bus.char_valid = 1'b1;
        is_hex         = 1'b1;
        hv             = nib[0] ? dbyte[3:0] : dbyte[7:4];
        if (acc) begin
          nib_d = nib + 3'd1;
          if (nib[0]) begin
            state_d = (rec_left == 5'd0) ? CSUM : FETCH;
            nib_d   = 3'd0;
          end
        end
      end
      CSUM: begin
        bus.char_valid = 1'b1;
        is_hex         = 1'b1;
        hv             = nib[0] ? ~sum[3:0] : ~sum[7:4];
        if (acc) begin
          nib_d = nib + 3'd1;
          if (nib[0]) begin
            state_d = CR;
            nib_d   = 3'd0;
          end
        end
      end
      CR: begin
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h0D;
        if (acc) state_d = LF;
      end
      LF: begin
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h0A;
        if (acc) begin
          nib_d = 3'd0;
          // An S3 record is always followed by another S3 or the S7.
          if (!s7) begin
            state_d = TYPE;
            setup   = 1'b1;
          end else begin
            state_d = IDLE;
            fin     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (is_hex) begin
      bus.char_data = (hv < 4'd10) ? 8'h30 + {4'h0, hv}
                                   : 8'h37 + {4'h0, hv};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s7       <= 1'b0;
      rem      <= 16'd0;
      n        <= 5'd0;
      rec_left <= 5'd0;
      cur      <= 32'd0;
      rec_addr <= 32'd0;
      base     <= 32'd0;
      dbyte    <= 8'd0;
      sum      <= 8'd0;
      sent     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (state != FETCH) sent <= 1'b0;
      else if (bus.read_request) sent <= 1'b1;
      if (setup) begin
        s7       <= s7_new;
        n        <= n_new;
        rec_left <= n_new;
        rec_addr <= a_new;
        sum      <= sum_new;
        if (state == IDLE) begin
          rem  <= byte_count;
          cur  <= start_address;
          base <= start_address;
        end
      end
      if (state == FETCH && sent && bus.read_valid) begin
        dbyte    <= bus.read_data;
        sum      <= sum + bus.read_data;
        cur      <= cur + 32'd1;
        rem      <= rem - 16'd1;
        rec_left <= rec_left - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_srec_emitter.sv
// Directed bench for srec_emitter: S-record text, handshakes, reset.
// Memory model returns (address low byte + 1) for every address.
module tb_srec_emitter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_address = 32'd0;
  logic [15:0] byte_count = 16'd0;
  logic        busy, done;
  int          n_assert = 0;
  int          n_fail = 0;

  srec_emitter_if bus();

  srec_emitter dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .start_address(start_address), .byte_count(byte_count),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem(logic [31:0] a);
    return a[7:0] + 8'd1;
  endfunction

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D) r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(string tag, string obs, string exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, vis(obs), vis(exp));
    end
  endtask

  task automatic quiet(string tag, int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.char_valid !== 1'b0 || bus.read_request !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic run(
    string tag, logic [31:0] sa, logic [15:0] bc, string exp,
    int rdy_wait, int rd_delay, int poke_cyc, int abort_n,
    bit start_on_done, logic [31:0] first_ra, int nreads_exp
  );
    string       got = "";
    int          cw = 0, cnt = 0, nreads = 0, ndone = 0, cyc = 0;
    int          bad_stab = 0, bad_addr = 0, bad_rd = 0, bad_busy = 0;
    logic [7:0]  held = 8'h00;
    logic [31:0] pa = 32'd0;
    bit          pend = 0, fin = 0;
    @(negedge clock);
    start = 1'b1;
    start_address = sa;
    byte_count = bc;
    while (!fin) begin
      @(negedge clock);
      cyc++;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        start_address = 32'hDEAD0000;
        byte_count = 16'd5;
      end
      bus.read_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          bus.read_valid = 1'b1;
          bus.read_data = mem(pa);
          pend = 0;
        end else cnt--;
      end
      if (bus.read_request) begin
        if (pend) bad_rd++;
        if (bus.read_address !== first_ra + 32'(nreads)) bad_addr++;
        nreads++;
        pend = 1;
        pa = bus.read_address;
        cnt = rd_delay;
      end
      if (bus.char_valid) begin
        if (cw > 0 && bus.char_data !== held) bad_stab++;
        held = bus.char_data;
        if (cw >= rdy_wait) begin
          bus.char_ready = 1'b1;
          got = {got, $sformatf("%c", bus.char_data)};
          cw = 0;
        end else begin
          bus.char_ready = 1'b0;
          cw++;
        end
      end else begin
        if (cw > 0) bad_stab++;
        bus.char_ready = 1'b0;
      end
      if (ndone == 0 && busy !== 1'b1) bad_busy++;
      if (done) begin
        ndone++;
        chk({tag, "_done_busy"}, busy, 1);
        if (start_on_done) begin
          start = 1'b1;
          start_address = 32'h0;
          byte_count = 16'd1;
        end
      end else if (ndone > 0) begin
        chk({tag, "_busy_after_done"}, busy, 0);
        fin = 1;
      end
      if (abort_n >= 0 && got.len() == abort_n) return;
      if (cyc > 5000) begin
        chk({tag, "_timeout"}, cyc, 5000);
        fin = 1;
      end
    end
    bus.char_ready = 1'b0;
    bus.read_valid = 1'b0;
    chk_s({tag, "_chars"}, got, exp);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_nreads"}, nreads, nreads_exp);
    chk({tag, "_read_addr"}, bad_addr, 0);
    chk({tag, "_read_overlap"}, bad_rd, 0);
    chk({tag, "_stable"}, bad_stab, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    quiet({tag, "_idle_after"}, 5);
  endtask

  localparam string E1 =
    "S30800000100010203F0\r\nS70500000100F9\r\n";

  initial begin
    bus.read_data  = 8'h00;
    bus.read_valid = 1'b0;
    bus.char_ready = 1'b0;
    #1;
    chk("rst_char_valid", bus.char_valid, 0);
    chk("rst_read_request", bus.read_request, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_char_data", bus.char_data, 8'h00);
    chk("rst_read_address", bus.read_address, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quiet("post_reset_idle", 4);

    run("basic", 32'h100, 16'd3, E1, 0, 0, -1, -1, 1, 32'h100, 3);

    run("slow", 32'h100, 16'd3, E1, 5, 3, 20, -1, 0, 32'h100, 3);

    run("zero", 32'h0, 16'd0, "S70500000000FA\r\n",
        0, 0, -1, -1, 0, 32'h0, 0);

    run("seventeen", 32'h1000, 16'd17,
        {"S31500001000", "0102030405060708090A0B0C0D0E0F10",
         "52\r\n", "S3060000101011C8\r\n", "S70500001000EA\r\n"},
        0, 1, -1, -1, 0, 32'h1000, 17);

    run("wrap", 32'hFFFFFFFE, 16'd4,
        "S309FFFFFFFEFF000102F9\r\nS705FFFFFFFEFF\r\n",
        1, 0, -1, -1, 0, 32'hFFFFFFFE, 4);

    run("abort", 32'h100, 16'd3, E1, 0, 0, -1, 6, 0, 32'h100, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_char_valid", bus.char_valid, 0);
    chk("abort_read_request", bus.read_request, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_char_data", bus.char_data, 8'h00);
    chk("abort_read_address", bus.read_address, 32'h0);
    bus.char_ready = 1'b0;
    bus.read_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    quiet("abort_idle", 10);

    run("after_abort", 32'h100, 16'd3, E1, 0, 0, -1, -1, 0, 32'h100, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
